uart_ctrl_p: RTL

- Parametrised next-generation UART controller: TX/RX engines, depth-configurable TX and RX FIFOs, 16x oversampled receiver, and a 4-register CSR bus slave.
- Adds the following runtime-programmable options: data length (5-8 bits), parity (none/even/odd), 1 or 2 stop bits.
- Adds a sticky error and overrun status, a loopback mode, and maskable level/threshold interrupts.
- Sits directly on the system register bus, driving the `tx` pin and sampling the `rx` pin.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_sync_fifo.sv | 49 ++++
 rtl/uart_ctrl_p.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types, register map and framing helpers for the uart_ctrl_p controller.
package uart_pkg;

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop1, TxStop2} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
  typedef enum logic [1:0] {ParNone, ParEven, ParOdd} parity_e;

  // Register index as decoded from addr[3:2]
  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegCtrl   = 2'd1;
  localparam logic [1:0] RegStatus = 2'd2;
  localparam logic [1:0] RegIe     = 2'd3;

  localparam int unsigned CtrlLenLsb  = 16;
  localparam int unsigned CtrlParEn   = 18;
  localparam int unsigned CtrlOdd     = 19;
  localparam int unsigned CtrlTwoStop = 20;
  localparam int unsigned CtrlTxEn    = 21;
  localparam int unsigned CtrlRxEn    = 22;
  localparam int unsigned CtrlLoop    = 23;
  localparam int unsigned CtrlThrLsb  = 24;

  localparam int unsigned StRxLvlLsb = 9;
  localparam int unsigned StTxFull   = 18;
  localparam int unsigned StRxEmpty  = 19;
  localparam int unsigned StTxBusy   = 20;
  localparam int unsigned StErrLsb   = 24;

  // Even parity over the low (5 + len) bits of data
  function automatic logic parity_of(logic [7:0] data, logic [1:0] len);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - len);
    return ^(data & mask);
  endfunction

  function automatic parity_e par_mode(logic en, logic odd);
    if (!en) return ParNone;
    return odd ? ParOdd : ParEven;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with exact level; push on full is accepted only alongside a pop.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LVL_W'(1);
      else if (do_pop && !do_push) level_q <= level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_ctrl_p.sv
// UART controller: CSR slave, baud generator, TX/RX framing engines and two FIFOs.
module uart_ctrl_p
  import uart_pkg::*;
#(
  parameter int unsigned     FIFO_DEPTH = 16,
  parameter int unsigned     DIV_W      = 16,
  parameter logic [DIV_W-1:0] RST_DIV   = DIV_W'(27)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_en,
  input  logic        r_en,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        ready,
  output logic        slverr,
  output logic        interupt,
  output logic        tx,
  input  logic        rx
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic unused_addr;
  assign unused_addr = ^{addr[31:4], addr[1:0]};

  // CTRL / IE state
  logic [DIV_W-1:0] div_q;
  logic [1:0]       len_q;
  logic             par_en_q, odd_q, two_stop_q, tx_en_q, rx_en_q, loop_q;
  logic [7:0]       thr_q;
  logic [2:0]       ie_q;
  logic [2:0]       err_q, err_d;  // {overrun, frame, parity}

  logic [1:0] sel;
  logic       ctrl_wr, tx_push, rx_pop, rx_push, set_par, set_frm, set_ovr;
  logic [7:0] tx_rdata, rx_rdata, rx_byte;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [LW-1:0] tx_level, rx_level;

  assign sel     = addr[3:2];
  assign ctrl_wr = w_en && (sel == RegCtrl);
  assign tx_push = w_en && (sel == RegData) && !tx_full;
  assign rx_pop  = r_en && !w_en && (sel == RegData) && !rx_empty;

  // Baud tick generator
  logic [DIV_W-1:0] baud_cnt_q, div_eff;
  logic             tick;

  assign div_eff = (div_q == '0) ? DIV_W'(1) : div_q;
  assign tick    = (baud_cnt_q >= div_eff - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (rst || ctrl_wr || tick) baud_cnt_q <= '0;
    else                        baud_cnt_q <= baud_cnt_q + DIV_W'(1);
  end

  // TX engine
  tx_state_e  tx_state_q, tx_state_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [1:0] tx_len_q, tx_len_d;
  parity_e    tx_mode_q, tx_mode_d;
  logic       tx_par_q, tx_par_d, tx_two_q, tx_two_d;
  logic       tx_pop, start_frame, tx_launch, tx_bit_end, tx_last, tx_line, tx_q;

  assign tx_launch  = tx_en_q && !tx_empty;
  assign tx_bit_end = tick && (tx_cnt_q == 4'd15);
  assign tx_last    = (tx_bit_q == ({1'b0, tx_len_q} + 3'd4));

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_len_d    = tx_len_q;
    tx_mode_d   = tx_mode_q;
    tx_par_d    = tx_par_q;
    tx_two_d    = tx_two_q;
    tx_pop      = 1'b0;
    start_frame = 1'b0;
    if (tx_state_q != TxIdle && tick) tx_cnt_d = tx_cnt_q + 4'd1;
    unique case (tx_state_q)
      TxIdle:   start_frame = tx_launch;
      TxStart:  if (tx_bit_end) tx_state_d = TxData;
      TxData: begin
        if (tx_bit_end) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_last) tx_state_d = (tx_mode_q == ParNone) ? TxStop1 : TxParity;
          else         tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      TxParity: if (tx_bit_end) tx_state_d = TxStop1;
      TxStop1: begin
        if (tx_bit_end) begin
          if (tx_two_q) tx_state_d = TxStop2;
          else begin
            tx_state_d  = TxIdle;
            start_frame = tx_launch;
          end
        end
      end
      TxStop2: begin
        if (tx_bit_end) begin
          tx_state_d  = TxIdle;
          start_frame = tx_launch;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    // Pop and framing snapshot coincide with entry to START; also chains frames with no gap
    if (start_frame) begin
      tx_state_d = TxStart;
      tx_pop     = 1'b1;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_shift_d = tx_rdata;
      tx_len_d   = len_q;
      tx_mode_d  = par_mode(par_en_q, odd_q);
      tx_par_d   = parity_of(tx_rdata, len_q) ^ odd_q;
      tx_two_d   = two_stop_q;
    end
  end

  always_comb begin
    tx_line = 1'b1;
    unique case (tx_state_q)
      TxStart:  tx_line = 1'b0;
      TxData:   tx_line = tx_shift_q[0];
      TxParity: tx_line = tx_par_q;
      default:  tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_len_q   <= '0;
      tx_mode_q  <= ParNone;
      tx_par_q   <= 1'b0;
      tx_two_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_len_q   <= tx_len_d;
      tx_mode_q  <= tx_mode_d;
      tx_par_q   <= tx_par_d;
      tx_two_q   <= tx_two_d;
      tx_q       <= loop_q ? 1'b1 : tx_line;
    end
  end

  assign tx = tx_q;

  // RX engine
  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [1:0] rx_len_q, rx_len_d;
  parity_e    rx_mode_q, rx_mode_d;
  logic       v7_q, v7_d, v8_q, v8_d, rx_pbad_q, rx_pbad_d;
  logic       rx_s1_q, rx_s2_q, rx_prev_q, rx_in, vote, rx_mid, rx_end, rx_last;

  assign rx_in   = loop_q ? tx_line : rx_s2_q;
  assign vote    = (v7_q & v8_q) | (v7_q & rx_in) | (v8_q & rx_in);
  assign rx_mid  = tick && (rx_cnt_q == 4'd9);
  assign rx_end  = tick && (rx_cnt_q == 4'd15);
  assign rx_last = (rx_bit_q == ({1'b0, rx_len_q} + 3'd4));
  assign rx_byte = rx_shift_q >> (2'd3 - rx_len_q);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_len_d   = rx_len_q;
    rx_mode_d  = rx_mode_q;
    v7_d       = v7_q;
    v8_d       = v8_q;
    rx_pbad_d  = rx_pbad_q;
    rx_push    = 1'b0;
    set_par    = 1'b0;
    set_frm    = 1'b0;
    if (rx_state_q != RxIdle && tick) begin
      rx_cnt_d = rx_cnt_q + 4'd1;
      if (rx_cnt_q == 4'd7) v7_d = rx_in;
      if (rx_cnt_q == 4'd8) v8_d = rx_in;
    end
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_en_q && rx_prev_q && !rx_in) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_pbad_d  = 1'b0;
          rx_len_d   = len_q;
          rx_mode_d  = par_mode(par_en_q, odd_q);
        end
      end
      RxStart: begin
        if (rx_mid && vote) rx_state_d = RxIdle;
        else if (rx_end)    rx_state_d = RxData;
      end
      RxData: begin
        // Bits enter from the top; rx_byte right-aligns short characters
        if (rx_mid) rx_shift_d = {vote, rx_shift_q[7:1]};
        if (rx_end) begin
          if (rx_last) rx_state_d = (rx_mode_q == ParNone) ? RxStop : RxParity;
          else         rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RxParity: begin
        if (rx_mid) rx_pbad_d = vote ^ parity_of(rx_byte, rx_len_q) ^ (rx_mode_q == ParOdd);
        if (rx_end) rx_state_d = RxStop;
      end
      RxStop: begin
        if (rx_mid) begin
          rx_push    = 1'b1;
          set_frm    = !vote;
          set_par    = rx_pbad_q;
          rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  assign set_ovr = rx_push && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_len_q   <= '0;
      rx_mode_q  <= ParNone;
      v7_q       <= 1'b1;
      v8_q       <= 1'b1;
      rx_pbad_q  <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_len_q   <= rx_len_d;
      rx_mode_q  <= rx_mode_d;
      v7_q       <= v7_d;
      v8_q       <= v8_d;
      rx_pbad_q  <= rx_pbad_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_in;
    end
  end

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (w_data[7:0]),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_byte),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  // CSR read views, sticky errors, bus response
  logic [31:0] ctrl_rd, status_rd, rdata_d;
  logic        slverr_d, irq_d, irq_q, ready_q, slverr_q;
  logic [31:0] r_data_q;

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[DIV_W-1:0]                 = div_q;
    ctrl_rd[CtrlLenLsb +: 2]           = len_q;
    ctrl_rd[CtrlParEn]                 = par_en_q;
    ctrl_rd[CtrlOdd]                   = odd_q;
    ctrl_rd[CtrlTwoStop]               = two_stop_q;
    ctrl_rd[CtrlTxEn]                  = tx_en_q;
    ctrl_rd[CtrlRxEn]                  = rx_en_q;
    ctrl_rd[CtrlLoop]                  = loop_q;
    ctrl_rd[CtrlThrLsb +: 8]           = thr_q;
    status_rd = '0;
    status_rd[8:0]                     = 9'(tx_level);
    status_rd[StRxLvlLsb +: 9]         = 9'(rx_level);
    status_rd[StTxFull]                = tx_full;
    status_rd[StRxEmpty]               = rx_empty;
    status_rd[StTxBusy]                = (tx_state_q != TxIdle);
    status_rd[StErrLsb +: 3]           = err_q;
  end

  always_comb begin
    rdata_d  = '0;
    slverr_d = 1'b0;
    if (w_en) begin
      slverr_d = r_en || ((sel == RegData) && tx_full);
    end else if (r_en) begin
      unique case (sel)
        RegData: begin
          if (rx_empty) slverr_d = 1'b1;
          else          rdata_d  = {24'd0, rx_rdata};
        end
        RegCtrl:   rdata_d = ctrl_rd;
        RegStatus: rdata_d = status_rd;
        default:   rdata_d = {29'd0, ie_q};
      endcase
    end
  end

  always_comb begin
    err_d = err_q;
    if (w_en && (sel == RegStatus)) err_d = err_d & ~w_data[StErrLsb +: 3];
    err_d = err_d | {set_ovr, set_frm, set_par};
  end

  assign irq_d = (ie_q[0] && ({1'b0, thr_q} <= 9'(rx_level)) && (thr_q != 8'd0)) ||
                 (ie_q[1] && (tx_level == '0) && (tx_state_q == TxIdle)) ||
                 (ie_q[2] && (err_q != 3'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= RST_DIV;
      len_q      <= 2'b11;
      par_en_q   <= 1'b0;
      odd_q      <= 1'b0;
      two_stop_q <= 1'b0;
      tx_en_q    <= 1'b0;
      rx_en_q    <= 1'b0;
      loop_q     <= 1'b0;
      thr_q      <= '0;
      ie_q       <= '0;
      err_q      <= '0;
      irq_q      <= 1'b0;
      ready_q    <= 1'b0;
      slverr_q   <= 1'b0;
      r_data_q   <= '0;
    end else begin
      if (ctrl_wr) begin
        div_q      <= w_data[DIV_W-1:0];
        len_q      <= w_data[CtrlLenLsb +: 2];
        par_en_q   <= w_data[CtrlParEn];
        odd_q      <= w_data[CtrlOdd];
        two_stop_q <= w_data[CtrlTwoStop];
        tx_en_q    <= w_data[CtrlTxEn];
        rx_en_q    <= w_data[CtrlRxEn];
        loop_q     <= w_data[CtrlLoop];
        thr_q      <= w_data[CtrlThrLsb +: 8];
      end
      if (w_en && (sel == RegIe)) ie_q <= w_data[2:0];
      err_q    <= err_d;
      irq_q    <= irq_d;
      ready_q  <= w_en || r_en;
      slverr_q <= slverr_d;
      r_data_q <= rdata_d;
    end
  end

  assign r_data   = r_data_q;
  assign ready    = ready_q;
  assign slverr   = slverr_q;
  assign interupt = irq_q;

endmodule
